// File: rtl/core_pipe_pkg.sv
// Shared definitions for the 5-stage core pipeline: control bundle layout,
// bubble encoding and small decode helpers.
package core_pipe_pkg;

  localparam int CTRL_W = 12;

  // Bit positions inside the packed control bundle
  localparam int CTRL_REG_WRITE      = 0;
  localparam int CTRL_MEM_READ       = 1;
  localparam int CTRL_MEM_WRITE      = 2;
  localparam int CTRL_ALU_SRC        = 3;
  localparam int CTRL_ALU_OP_LSB     = 4;
  localparam int CTRL_ALU_OP_MSB     = 6;
  localparam int CTRL_RESULT_SRC_LSB = 7;
  localparam int CTRL_RESULT_SRC_MSB = 8;
  localparam int CTRL_BRANCH         = 9;
  localparam int CTRL_JUMP           = 10;
  localparam int CTRL_JALR           = 11;

  typedef struct packed {
    logic       jalr;
    logic       jump;
    logic       branch;
    logic [1:0] result_src;
    logic [2:0] alu_op;
    logic       alu_src;
    logic       mem_write;
    logic       mem_read;
    logic       reg_write;
  } ctrl_t;

  localparam logic [CTRL_W-1:0] CTRL_BUBBLE = 12'h000;

  typedef enum logic [1:0] {
    BUB_NONE     = 2'd0,
    BUB_LOAD_USE = 2'd1,
    BUB_FLUSH    = 2'd2
  } bubble_cause_e;

  function automatic logic ctrl_mem_read(input logic [CTRL_W-1:0] ctrl);
    ctrl_t c;
    c = ctrl_t'(ctrl);
    return c.mem_read;
  endfunction

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard detector: a load in EX whose destination is read by the
// instruction in ID. A concurrent EX flush suppresses the stall.
module hazard_detect
  import core_pipe_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  ex_valid,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic                  flush_ex,
  output logic                  load_use,
  output logic                  stall
);

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = {REG_ADDR_W{1'b0}};

  logic rs1_hit_s;
  logic rs2_hit_s;

  // Source-operand match against the pending load destination
  always_comb begin
    rs1_hit_s = 1'b0;
    rs2_hit_s = 1'b0;
    load_use  = 1'b0;
    stall     = 1'b0;
    if (ex_valid && ex_mem_read && (ex_rd != REG_ZERO) && id_valid) begin
      rs1_hit_s = id_uses_rs1 && (id_rs1 == ex_rd);
      rs2_hit_s = id_uses_rs2 && (id_rs2 == ex_rd);
      load_use  = rs1_hit_s || rs2_hit_s;
    end else begin
      load_use  = 1'b0;
    end
    // Wrong-path ID instruction: let PC take the redirect target instead
    if (flush_ex) begin
      stall = 1'b0;
    end else begin
      stall = load_use;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall generation, bubble insertion
// on stall or EX flush, and a saturating bubble counter.
module id_ex_stage
  import core_pipe_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [XLEN-1:0]       id_pc,
  input  logic [XLEN-1:0]       id_reg1_data,
  input  logic [XLEN-1:0]       id_reg2_data,
  input  logic [XLEN-1:0]       id_imm,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic [CTRL_W-1:0]     id_ctrl,
  input  logic                  flush_ex,
  output logic                  ex_valid,
  output logic [XLEN-1:0]       ex_pc,
  output logic [XLEN-1:0]       ex_reg1_data,
  output logic [XLEN-1:0]       ex_reg2_data,
  output logic [XLEN-1:0]       ex_imm,
  output logic [REG_ADDR_W-1:0] ex_rs1,
  output logic [REG_ADDR_W-1:0] ex_rs2,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic [CTRL_W-1:0]     ex_ctrl,
  output logic                  pc_write_en,
  output logic                  if_id_write_en,
  output logic [CNT_W-1:0]      bubble_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic                  ex_valid_r;
  logic [XLEN-1:0]       ex_pc_r;
  logic [XLEN-1:0]       ex_reg1_data_r;
  logic [XLEN-1:0]       ex_reg2_data_r;
  logic [XLEN-1:0]       ex_imm_r;
  logic [REG_ADDR_W-1:0] ex_rs1_r;
  logic [REG_ADDR_W-1:0] ex_rs2_r;
  logic [REG_ADDR_W-1:0] ex_rd_r;
  logic [CTRL_W-1:0]     ex_ctrl_r;
  logic [CNT_W-1:0]      bubble_count_r;

  logic          load_use_s;
  logic          stall_s;
  logic          write_en_s;
  bubble_cause_e cause_s;

  hazard_detect #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_hazard_detect (
    .ex_valid    (ex_valid_r),
    .ex_mem_read (ctrl_mem_read(ex_ctrl_r)),
    .ex_rd       (ex_rd_r),
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_uses_rs1 (id_uses_rs1),
    .id_uses_rs2 (id_uses_rs2),
    .flush_ex    (flush_ex),
    .load_use    (load_use_s),
    .stall       (stall_s)
  );

  // Bubble cause selection and front-end write enables
  always_comb begin
    cause_s    = BUB_NONE;
    write_en_s = 1'b1;
    if (flush_ex) begin
      cause_s = BUB_FLUSH;
    end else if (load_use_s) begin
      cause_s = BUB_LOAD_USE;
    end else begin
      cause_s = BUB_NONE;
    end
    // Front end is never held while the core is in reset
    if (reset) begin
      write_en_s = 1'b1;
    end else begin
      write_en_s = ~stall_s;
    end
  end

  // ID/EX pipeline register; payload loads even on a bubble to stay deterministic
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid_r     <= 1'b0;
      ex_pc_r        <= {XLEN{1'b0}};
      ex_reg1_data_r <= {XLEN{1'b0}};
      ex_reg2_data_r <= {XLEN{1'b0}};
      ex_imm_r       <= {XLEN{1'b0}};
      ex_rs1_r       <= {REG_ADDR_W{1'b0}};
      ex_rs2_r       <= {REG_ADDR_W{1'b0}};
      ex_rd_r        <= {REG_ADDR_W{1'b0}};
      ex_ctrl_r      <= CTRL_BUBBLE;
    end else begin
      ex_pc_r        <= id_pc;
      ex_reg1_data_r <= id_reg1_data;
      ex_reg2_data_r <= id_reg2_data;
      ex_imm_r       <= id_imm;
      ex_rs1_r       <= id_rs1;
      ex_rs2_r       <= id_rs2;
      ex_rd_r        <= id_rd;
      case (cause_s)
        BUB_NONE: begin
          ex_valid_r <= id_valid;
          ex_ctrl_r  <= id_valid ? id_ctrl : CTRL_BUBBLE;
        end
        BUB_LOAD_USE, BUB_FLUSH: begin
          ex_valid_r <= 1'b0;
          ex_ctrl_r  <= CTRL_BUBBLE;
        end
        default: begin
          ex_valid_r <= 1'b0;
          ex_ctrl_r  <= CTRL_BUBBLE;
        end
      endcase
    end
  end

  // Saturating count of bubbles that displaced a real instruction
  always_ff @(posedge clk) begin
    if (reset) begin
      bubble_count_r <= {CNT_W{1'b0}};
    end else begin
      case (cause_s)
        BUB_LOAD_USE, BUB_FLUSH: begin
          if (id_valid && (bubble_count_r != CNT_MAX)) begin
            bubble_count_r <= bubble_count_r + CNT_ONE;
          end else begin
            bubble_count_r <= bubble_count_r;
          end
        end
        BUB_NONE: begin
          bubble_count_r <= bubble_count_r;
        end
        default: begin
          bubble_count_r <= bubble_count_r;
        end
      endcase
    end
  end

  assign ex_valid       = ex_valid_r;
  assign ex_pc          = ex_pc_r;
  assign ex_reg1_data   = ex_reg1_data_r;
  assign ex_reg2_data   = ex_reg2_data_r;
  assign ex_imm         = ex_imm_r;
  assign ex_rs1         = ex_rs1_r;
  assign ex_rs2         = ex_rs2_r;
  assign ex_rd          = ex_rd_r;
  assign ex_ctrl        = ex_ctrl_r;
  assign pc_write_en    = write_en_s;
  assign if_id_write_en = write_en_s;
  assign bubble_count   = bubble_count_r;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: an independent reference model predicts
// the EX register contents and write enables for every driven cycle.
module tb_id_ex_stage;

  localparam int XLEN  = 32;
  localparam int RW    = 5;
  localparam int CW    = 12;
  localparam int CNT_W = 4;

  typedef struct packed {
    logic            v;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] r1;
    logic [XLEN-1:0] r2;
    logic [XLEN-1:0] imm;
    logic [RW-1:0]   rs1;
    logic [RW-1:0]   rs2;
    logic [RW-1:0]   rd;
    logic            u1;
    logic            u2;
    logic [CW-1:0]   ctrl;
    logic            fl;
    logic            rst;
  } stim_t;

  typedef struct packed {
    logic             valid;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  r1;
    logic [XLEN-1:0]  r2;
    logic [XLEN-1:0]  imm;
    logic [RW-1:0]    rs1;
    logic [RW-1:0]    rs2;
    logic [RW-1:0]    rd;
    logic [CW-1:0]    ctrl;
    logic [CNT_W-1:0] cnt;
  } ex_t;

  logic            clk = 1'b0;
  logic            reset;
  logic            id_valid;
  logic [XLEN-1:0] id_pc, id_reg1_data, id_reg2_data, id_imm;
  logic [RW-1:0]   id_rs1, id_rs2, id_rd;
  logic            id_uses_rs1, id_uses_rs2;
  logic [CW-1:0]   id_ctrl;
  logic            flush_ex;
  logic            ex_valid;
  logic [XLEN-1:0] ex_pc, ex_reg1_data, ex_reg2_data, ex_imm;
  logic [RW-1:0]   ex_rs1, ex_rs2, ex_rd;
  logic [CW-1:0]   ex_ctrl;
  logic            pc_write_en, if_id_write_en;
  logic [CNT_W-1:0] bubble_count;

  int n_checks = 0;
  int n_errors = 0;
  ex_t model = '0;
  ex_t exp_q[$];

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(XLEN), .REG_ADDR_W(RW), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_pc(id_pc),
    .id_reg1_data(id_reg1_data), .id_reg2_data(id_reg2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_ctrl(id_ctrl),
    .flush_ex(flush_ex), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_reg1_data(ex_reg1_data), .ex_reg2_data(ex_reg2_data), .ex_imm(ex_imm),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_ctrl(ex_ctrl),
    .pc_write_en(pc_write_en), .if_id_write_en(if_id_write_en),
    .bubble_count(bubble_count)
  );

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic stim_t mk(input logic v, input logic [XLEN-1:0] pc,
                               input logic [XLEN-1:0] r1, input logic [XLEN-1:0] r2,
                               input logic [RW-1:0] rs1, input logic u1,
                               input logic [RW-1:0] rs2, input logic u2,
                               input logic [RW-1:0] rd, input logic [CW-1:0] ctrl,
                               input logic fl, input logic rst);
    stim_t s;
    s.v = v; s.pc = pc; s.r1 = r1; s.r2 = r2; s.imm = pc ^ 32'h0000_0F0F;
    s.rs1 = rs1; s.rs2 = rs2; s.rd = rd; s.u1 = u1; s.u2 = u2;
    s.ctrl = ctrl; s.fl = fl; s.rst = rst;
    return s;
  endfunction

  // Drive one ID cycle, check the enables, then compare the EX result after the edge
  task automatic step(input stim_t s);
    logic lu, exp_we, bub;
    ex_t  nxt, got;
    @(negedge clk);
    reset = s.rst; id_valid = s.v; id_pc = s.pc; id_reg1_data = s.r1;
    id_reg2_data = s.r2; id_imm = s.imm; id_rs1 = s.rs1; id_rs2 = s.rs2;
    id_rd = s.rd; id_uses_rs1 = s.u1; id_uses_rs2 = s.u2; id_ctrl = s.ctrl;
    flush_ex = s.fl;
    #1;
    lu = model.valid && model.ctrl[1] && (model.rd != 5'd0) && s.v &&
         ((s.u1 && (s.rs1 == model.rd)) || (s.u2 && (s.rs2 == model.rd)));
    exp_we = s.rst || !(lu && !s.fl);
    check_eq("pc_write_en", {63'd0, pc_write_en}, {63'd0, exp_we});
    check_eq("if_id_write_en", {63'd0, if_id_write_en}, {63'd0, exp_we});
    if (s.rst) begin
      nxt = '0;
    end else begin
      bub = s.fl || lu;
      nxt.pc = s.pc; nxt.r1 = s.r1; nxt.r2 = s.r2; nxt.imm = s.imm;
      nxt.rs1 = s.rs1; nxt.rs2 = s.rs2; nxt.rd = s.rd;
      nxt.valid = bub ? 1'b0 : s.v;
      nxt.ctrl = (bub || !s.v) ? 12'h000 : s.ctrl;
      nxt.cnt = model.cnt;
      if (bub && s.v && (model.cnt != 4'hF)) nxt.cnt = model.cnt + 4'd1;
    end
    exp_q.push_back(nxt);
    model = nxt;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check_eq("scoreboard_empty", 64'd1, 64'd0);
    end else begin
      got = exp_q.pop_front();
      check_eq("ex_valid", {63'd0, ex_valid}, {63'd0, got.valid});
      check_eq("ex_pc", {32'd0, ex_pc}, {32'd0, got.pc});
      check_eq("ex_reg1_data", {32'd0, ex_reg1_data}, {32'd0, got.r1});
      check_eq("ex_reg2_data", {32'd0, ex_reg2_data}, {32'd0, got.r2});
      check_eq("ex_imm", {32'd0, ex_imm}, {32'd0, got.imm});
      check_eq("ex_rs1", {59'd0, ex_rs1}, {59'd0, got.rs1});
      check_eq("ex_rs2", {59'd0, ex_rs2}, {59'd0, got.rs2});
      check_eq("ex_rd", {59'd0, ex_rd}, {59'd0, got.rd});
      check_eq("ex_ctrl", {52'd0, ex_ctrl}, {52'd0, got.ctrl});
      check_eq("bubble_count", {60'd0, bubble_count}, {60'd0, got.cnt});
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    stim_t s;
    reset = 1'b1; id_valid = 1'b0; id_pc = '0; id_reg1_data = '0; id_reg2_data = '0;
    id_imm = '0; id_rs1 = '0; id_rs2 = '0; id_rd = '0; id_uses_rs1 = 1'b0;
    id_uses_rs2 = 1'b0; id_ctrl = '0; flush_ex = 1'b0;

    // Reset two cycles, then plain flow
    step(mk(1'b1, 32'h8, 32'h1, 32'h2, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 12'h001, 1'b1, 1'b1));
    step(mk(1'b1, 32'h8, 32'h1, 32'h2, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 12'h003, 1'b0, 1'b1));
    step(mk(1'b1, 32'h10, 32'hAAAA0001, 32'h5, 5'd2, 1'b1, 5'd3, 1'b1, 5'd1, 12'h001, 1'b0, 1'b0));
    // Load-use: lw x5 then add reading x5 -> one bubble, then add proceeds
    step(mk(1'b1, 32'h14, 32'h100, 32'h0, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 12'h003, 1'b0, 1'b0));
    step(mk(1'b1, 32'h18, 32'h7, 32'h8, 5'd5, 1'b1, 5'd6, 1'b1, 5'd4, 12'h001, 1'b0, 1'b0));
    step(mk(1'b1, 32'h18, 32'h7, 32'h8, 5'd5, 1'b1, 5'd6, 1'b1, 5'd4, 12'h001, 1'b0, 1'b0));
    // lw rd=x0 never hazards
    step(mk(1'b1, 32'h1C, 32'h0, 32'h0, 5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 12'h003, 1'b0, 1'b0));
    step(mk(1'b1, 32'h20, 32'h0, 32'h0, 5'd0, 1'b1, 5'd0, 1'b1, 5'd8, 12'h001, 1'b0, 1'b0));
    // lw x7, ID names rs2=7 without reading it
    step(mk(1'b1, 32'h24, 32'h0, 32'h0, 5'd1, 1'b1, 5'd0, 1'b0, 5'd7, 12'h003, 1'b0, 1'b0));
    step(mk(1'b1, 32'h28, 32'h3, 32'h4, 5'd1, 1'b1, 5'd7, 1'b0, 5'd9, 12'h009, 1'b0, 1'b0));
    // Flush with a valid ID instruction
    step(mk(1'b1, 32'h2C, 32'h5, 32'h6, 5'd2, 1'b1, 5'd3, 1'b1, 5'd10, 12'h001, 1'b1, 1'b0));
    // Flush coincident with load-use: single bubble, PC not held
    step(mk(1'b1, 32'h30, 32'h0, 32'h0, 5'd1, 1'b1, 5'd0, 1'b0, 5'd9, 12'h003, 1'b0, 1'b0));
    step(mk(1'b1, 32'h34, 32'h1, 32'h2, 5'd9, 1'b1, 5'd9, 1'b1, 5'd11, 12'h001, 1'b1, 1'b0));
    // Flush over an empty ID slot is not counted
    step(mk(1'b0, 32'h38, 32'h0, 32'h0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 12'h001, 1'b1, 1'b0));
    // Invalid ID without flush carries no control
    step(mk(1'b0, 32'h3C, 32'h1, 32'h1, 5'd1, 1'b0, 5'd1, 1'b0, 5'd1, 12'h7FF, 1'b0, 1'b0));
    // Drive the counter into saturation
    for (int i = 0; i < 20; i++) begin
      step(mk(1'b1, 32'h100 + 32'(i * 4), 32'(i), 32'(i + 1), 5'd1, 1'b1, 5'd2, 1'b1,
              5'd3, 12'h001, 1'b1, 1'b0));
    end
    // Reset while EX holds a valid instruction, coincident with a flush
    step(mk(1'b1, 32'h200, 32'hDEAD, 32'hBEEF, 5'd1, 1'b1, 5'd2, 1'b1, 5'd12, 12'h005, 1'b0, 1'b0));
    step(mk(1'b1, 32'h204, 32'h1234, 32'h5678, 5'd12, 1'b1, 5'd2, 1'b1, 5'd13, 12'h003, 1'b1, 1'b1));
    // Randomised traffic on a small register range to provoke hazards
    for (int i = 0; i < 150; i++) begin
      s = mk(($urandom_range(0, 7) != 0), $urandom(), $urandom(), $urandom(),
             5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             5'($urandom_range(0, 3)), 12'($urandom_range(0, 4095)),
             ($urandom_range(0, 7) == 0), ($urandom_range(0, 39) == 0));
      step(s);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
